intr_ctrl_prio: RTL and testbench
=================================

Name: intr_ctrl_prio

Overview:
Parametrised successor to the team's APB-programmed priority interrupt controller. Per-source programmable priority, enable mask, and per-source edge/level mode; edge events are latched into a pending register. A two-state service FSM presents one winning interrupt id until software acknowledges it via intr_serviced_i. Sits between peripheral interrupt lines and the processor-side interrupt handler, configured over APB.

Parameters:
NUM_INTR, 16, number of interrupt sources (2..32)
PRIO_W, 4, priority field width; value 0 = never serviced
ADDR_W, 8, APB word-index address width
DATA_W, 32, APB data width (must be >= NUM_INTR and >= PRIO_W)
IDW, $clog2(NUM_INTR), id width (derived, not overridden)

Ports:
pclk_i  in  1  clock; all logic on rising edge
prst_i  in  1  reset, synchronous, active-low
paddr_i  in  ADDR_W  register word index
pwdata_i  in  DATA_W  write data
pwrite_i  in  1  1 = write
psel_i  in  1  APB select
penable_i  in  1  APB access phase
prdata_o  out  DATA_W  read data, valid while pready_o=1
pready_o  out  1  transfer complete
pslverr_o  out  1  unmapped-address error, valid while pready_o=1
intr_active_i  in  NUM_INTR  raw interrupt lines
intr_to_service_o  out  IDW  id being presented
intr_valid_o  out  1  intr_to_service_o valid
intr_serviced_i  in  1  one-cycle acknowledge of presented id

Behaviour:
- Reset (prst_i=0 at an edge): all outputs 0; prio[*]=0, enable=0, mode=0 (level), pending=0, edge-sample register=0, FSM=IDLE, pready state cleared. Reset mid-transfer or mid-service aborts everything; no ack is required afterwards.
- Register map (word index): 0..NUM_INTR-1 PRIO[i] RW bits[PRIO_W-1:0]; NUM_INTR ENABLE RW; NUM_INTR+1 MODE RW (1=edge, 0=level); NUM_INTR+2 PENDING RO, write-1-to-clear edge bits only; NUM_INTR+3 STATUS RO {bit IDW = intr_valid_o, bits[IDW-1:0] = intr_to_service_o}. Unused upper bits read 0, writes ignored.
- APB: one wait state. First access-phase cycle (psel&penable&!pready_o): at the edge, pready_o<=1, prdata_o/pslverr_o registered. Second cycle: pready_o=1, write commits at its end edge, then pready_o<=0. Unmapped index: pslverr_o=1, prdata_o=0, no state change. Writes to RO STATUS: ignored, no error. Setup phase (psel&!penable) has no effect.
- Edge detect: rise[i] = intr_active_i[i] & ~sample_q[i]; sample_q registered every cycle. If MODE[i]=1, pending[i] set at the edge where rise[i] is seen. Set beats W1C and ack-clear in the same cycle.
- Effective request: req[i] = ENABLE[i] & (PRIO[i]!=0) & (MODE[i] ? pending[i] : intr_active_i[i]).
- Arbitration: highest PRIO wins; tie -> lowest index. Combinational over req.
- FSM IDLE: if any req at an edge -> capture winner into intr_to_service_o, intr_valid_o<=1, go SERVICE. Latency: level line high before edge k -> valid after edge k; edge source rising seen at edge k -> pending after k -> valid after k+1.
- FSM SERVICE: id and valid held stable regardless of PRIO/ENABLE/MODE writes or lines dropping. intr_serviced_i=1 at an edge -> intr_valid_o<=0, clear pending[id] if MODE[id]=1 (unless set again same cycle), go IDLE. IDLE spends at least one cycle (valid low >= 1 cycle between grants).
- intr_serviced_i in IDLE: ignored. Level source still high after ack: re-requests after the IDLE cycle.
- Config writes take effect for arbitration from the cycle after commit.

Test Plan:
- Reset, then read every map index -> all 0, pslverr_o=0; read index NUM_INTR+4 -> pslverr_o=1, prdata_o=0; every transfer shows pready_o high exactly one cycle after the first access cycle.
- PRIO[i]=i, ENABLE=0xFFFF, MODE=0, intr_active_i=0x00A4 -> id 7 valid one cycle later; ack -> valid low for 1 cycle, then id 7 again while line held; drop bit 7 then ack -> id 5 next.
- Tie: PRIO[3]=PRIO[9]=6, both level-active -> id 3; ack with line 3 low -> id 9.
- Edge mode MODE=0x0010, PRIO[4]=2: 1-cycle pulse on line 4 -> PENDING bit4=1, valid id 4 two edges after pulse; ack -> PENDING=0; pulse again in the ack cycle -> PENDING stays 1, id 4 re-presented.
- In SERVICE with id 2, write PRIO[2]=0 and ENABLE=0 -> id 2 and valid unchanged until ack; afterwards no grant.
- W1C on PENDING bit 4 with no ack -> bit clears and no grant once out of SERVICE; assert prst_i=0 mid-SERVICE -> valid and id 0 next cycle, all registers 0.

Source files
------------

// File: rtl/intr_ctrl_prio.sv
// Priority interrupt controller: APB-programmed per-source priority/enable/mode, edge pending latch, one-id service FSM.
// Latency: level request -> intr_valid_o 1 cycle; edge -> 2 cycles; APB transfers take one wait state.
// Backpressure: a presented id is held until intr_serviced_i; APB stalls each access for exactly one cycle.
module intr_ctrl_prio #(
  parameter  int NUM_INTR = 16,
  parameter  int PRIO_W   = 4,
  parameter  int ADDR_W   = 8,
  parameter  int DATA_W   = 32,
  localparam int IDW      = $clog2(NUM_INTR)
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic                pwrite_i,
  input  logic                psel_i,
  input  logic                penable_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic [NUM_INTR-1:0] intr_active_i,
  output logic [IDW-1:0]      intr_to_service_o,
  output logic                intr_valid_o,
  input  logic                intr_serviced_i
);

  localparam logic [ADDR_W-1:0] A_ENABLE = ADDR_W'(NUM_INTR);
  localparam logic [ADDR_W-1:0] A_MODE   = ADDR_W'(NUM_INTR + 1);
  localparam logic [ADDR_W-1:0] A_PEND   = ADDR_W'(NUM_INTR + 2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_INTR + 3);

  typedef enum logic {S_IDLE = 1'b0, S_SERVICE = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [PRIO_W-1:0]   prio_q [NUM_INTR];
  logic [NUM_INTR-1:0] enable_q, mode_q, pending_q, pending_d, sample_q;
  logic [IDW-1:0]      id_q, id_d;
  logic                valid_q, valid_d;
  logic                pready_q, pslverr_q;
  logic [DATA_W-1:0]   prdata_q;

  logic                access_first, addr_mapped, wr_commit;
  logic [DATA_W-1:0]   rdata;
  logic [NUM_INTR-1:0] rise, w1c, ack_clr, req;
  logic [PRIO_W-1:0]   best_prio;
  logic [IDW-1:0]      best_id;
  logic                unused_pwdata;

  // Only the low NUM_INTR/PRIO_W bits of write data carry meaning.
  assign unused_pwdata = ^pwdata_i;

  assign access_first = psel_i & penable_i & ~pready_q;
  assign addr_mapped  = (paddr_i <= A_STATUS);
  // Writes land on the completing cycle of the transfer; unmapped indices never change state.
  assign wr_commit    = psel_i & penable_i & pready_q & pwrite_i & addr_mapped;

  assign prdata_o          = prdata_q;
  assign pready_o          = pready_q;
  assign pslverr_o         = pslverr_q;
  assign intr_to_service_o = id_q;
  assign intr_valid_o      = valid_q;

  // Read mux over the register map; unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_INTR; i++) begin
      if (paddr_i == ADDR_W'(i)) rdata = DATA_W'(prio_q[i]);
    end
    if (paddr_i == A_ENABLE) rdata = DATA_W'(enable_q);
    if (paddr_i == A_MODE)   rdata = DATA_W'(mode_q);
    if (paddr_i == A_PEND)   rdata = DATA_W'(pending_q);
    if (paddr_i == A_STATUS) rdata = DATA_W'({valid_q, id_q});
  end

  // APB handshake: registered response on the first access cycle, pready drops after completion.
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else if (access_first) begin
      pready_q  <= 1'b1;
      pslverr_q <= ~addr_mapped;
      prdata_q  <= addr_mapped ? rdata : '0;
    end else if (pready_q) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end
  end

  // Configuration registers (priority, enable, mode) written by committed APB writes.
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      for (int i = 0; i < NUM_INTR; i++) prio_q[i] <= '0;
      enable_q <= '0;
      mode_q   <= '0;
    end else if (wr_commit) begin
      for (int i = 0; i < NUM_INTR; i++) begin
        if (paddr_i == ADDR_W'(i)) prio_q[i] <= pwdata_i[PRIO_W-1:0];
      end
      if (paddr_i == A_ENABLE) enable_q <= pwdata_i[NUM_INTR-1:0];
      if (paddr_i == A_MODE)   mode_q   <= pwdata_i[NUM_INTR-1:0];
    end
  end

  // Pending next-state: a fresh rising edge always wins over W1C and acknowledge clears.
  always_comb begin
    rise    = intr_active_i & ~sample_q;
    w1c     = (wr_commit && paddr_i == A_PEND) ? pwdata_i[NUM_INTR-1:0] : '0;
    ack_clr = '0;
    for (int i = 0; i < NUM_INTR; i++) begin
      if (state_q == S_SERVICE && intr_serviced_i && id_q == IDW'(i) && mode_q[i]) ack_clr[i] = 1'b1;
    end
    pending_d = (pending_q & ~w1c & ~ack_clr) | (mode_q & rise);
  end

  // Edge sampler and pending latch.
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      sample_q  <= '0;
      pending_q <= '0;
    end else begin
      sample_q  <= intr_active_i;
      pending_q <= pending_d;
    end
  end

  // Arbiter: strict '>' keeps the lowest index on a priority tie; priority 0 never requests.
  always_comb begin
    req       = '0;
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < NUM_INTR; i++) begin
      req[i] = enable_q[i] & (prio_q[i] != '0) & (mode_q[i] ? pending_q[i] : intr_active_i[i]);
    end
    for (int i = 0; i < NUM_INTR; i++) begin
      if (req[i] && prio_q[i] > best_prio) begin
        best_prio = prio_q[i];
        best_id   = IDW'(i);
      end
    end
  end

  // Service FSM next-state: grant from IDLE, hold the presented id until acknowledged.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          id_d    = best_id;
          valid_d = 1'b1;
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (intr_serviced_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Service FSM state register.
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_intr_ctrl_prio.sv
// Directed bench for intr_ctrl_prio: register map, arbitration vectors, edge/ack/reset sequences.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.
// APB transfers are checked for exactly one wait state.
module tb_intr_ctrl_prio;
  localparam int N = 16, AW = 8, DW = 32, IW = 4;
  localparam int A_EN = 16, A_MODE = 17, A_PEND = 18, A_STAT = 19;

  logic          clk = 1'b0;
  logic          prst = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic          pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic [N-1:0]  active = '0;
  logic [IW-1:0] id;
  logic          valid;
  logic          serviced = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  intr_ctrl_prio #(.NUM_INTR(N), .PRIO_W(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk_i(clk), .prst_i(prst), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
    .psel_i(psel), .penable_i(penable), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .intr_active_i(active), .intr_to_service_o(id), .intr_valid_o(valid),
    .intr_serviced_i(serviced)
  );

  typedef struct {
    int          addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } rd_vec_t;

  typedef struct {
    logic [15:0] en;
    logic [15:0] act;
    logic        exp_valid;
    logic [3:0]  exp_id;
  } arb_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input int addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = AW'(addr); pwdata = wdata;
    tick();
    penable = 1'b1;
    check("pready_wait", 32'(pready), 32'd0);
    tick();
    check("pready_high", 32'(pready), 32'd1);
    rdata = prdata;
    err   = pslverr;
    tick();
    check("pready_drop", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input int addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, addr, data, rd, err);
    check("wr_err", 32'(err), 32'd0);
  endtask

  task automatic apb_rd(input int addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b0, addr, 32'd0, rd, err);
    check("rd_data", rd, exp);
    check("rd_err", 32'(err), 32'd0);
  endtask

  task automatic ack();
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rd_vec_t     rv[22];
    arb_vec_t    av[7];
    logic [31:0] rd;
    logic        err;

    for (int i = 0; i < 20; i++) rv[i] = '{addr: i, exp_data: 32'd0, exp_err: 1'b0};
    rv[20] = '{addr: 20, exp_data: 32'd0, exp_err: 1'b1};
    rv[21] = '{addr: 255, exp_data: 32'd0, exp_err: 1'b1};

    av[0] = '{en: 16'hFFFF, act: 16'h00A4, exp_valid: 1'b1, exp_id: 4'd7};
    av[1] = '{en: 16'hFFFF, act: 16'h0001, exp_valid: 1'b0, exp_id: 4'd0};
    av[2] = '{en: 16'hFF7F, act: 16'h00A4, exp_valid: 1'b1, exp_id: 4'd5};
    av[3] = '{en: 16'h0000, act: 16'hFFFF, exp_valid: 1'b0, exp_id: 4'd0};
    av[4] = '{en: 16'hFFFF, act: 16'h8001, exp_valid: 1'b1, exp_id: 4'd15};
    av[5] = '{en: 16'h00FF, act: 16'hFF00, exp_valid: 1'b0, exp_id: 4'd0};
    av[6] = '{en: 16'hFFFF, act: 16'h0006, exp_valid: 1'b1, exp_id: 4'd2};

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    prst = 1'b1;
    tick();

    // Register map after reset, including unmapped indices
    for (int i = 0; i < 22; i++) begin
      apb_xfer(1'b0, rv[i].addr, 32'd0, rd, err);
      check($sformatf("map_data[%0d]", rv[i].addr), rd, rv[i].exp_data);
      check($sformatf("map_err[%0d]", rv[i].addr), 32'(err), 32'(rv[i].exp_err));
    end
    apb_wr(A_STAT, 32'hFF);
    apb_rd(A_STAT, 32'd0);
    apb_xfer(1'b1, 20, 32'hFFFF, rd, err);
    check("unmapped_wr_err", 32'(err), 32'd1);

    // PRIO[i] = i, level mode
    for (int i = 0; i < N; i++) apb_wr(i, 32'(i));
    apb_rd(7, 32'd7);

    // Arbitration vectors
    for (int v = 0; v < 7; v++) begin
      apb_wr(A_EN, 32'(av[v].en));
      active = av[v].act;
      tick();
      check($sformatf("arb_valid[%0d]", v), 32'(valid), 32'(av[v].exp_valid));
      if (av[v].exp_valid) check($sformatf("arb_id[%0d]", v), 32'(id), 32'(av[v].exp_id));
      active = '0;
      if (av[v].exp_valid) ack();
      tick();
    end

    // Level re-request after ack, then fall back to the next source
    apb_wr(A_EN, 32'hFFFF);
    active = 16'h00A4;
    tick();
    check("lvl_id7", {28'd0, valid, id[2:0]}, {28'd0, 1'b1, 3'd7});
    ack();
    check("lvl_gap", 32'(valid), 32'd0);
    tick();
    check("lvl_regrant", {27'd0, valid, id}, {27'd0, 1'b1, 4'd7});
    active = 16'h0024;
    ack();
    check("lvl_gap2", 32'(valid), 32'd0);
    tick();
    check("lvl_id5", {27'd0, valid, id}, {27'd0, 1'b1, 4'd5});
    active = '0;
    ack();
    tick();

    // Priority tie -> lowest index
    apb_wr(3, 32'd6);
    apb_wr(9, 32'd6);
    active = 16'h0208;
    tick();
    check("tie_id3", {27'd0, valid, id}, {27'd0, 1'b1, 4'd3});
    active = 16'h0200;
    ack();
    check("tie_gap", 32'(valid), 32'd0);
    tick();
    check("tie_id9", {27'd0, valid, id}, {27'd0, 1'b1, 4'd9});
    active = '0;
    ack();
    tick();

    // Edge mode on source 4
    apb_wr(A_MODE, 32'h0010);
    apb_wr(4, 32'd2);
    active = 16'h0010;
    tick();
    active = '0;
    check("edge_not_yet", 32'(valid), 32'd0);
    tick();
    check("edge_grant", {27'd0, valid, id}, {27'd0, 1'b1, 4'd4});
    apb_rd(A_PEND, 32'h10);
    ack();
    check("edge_ack_valid", 32'(valid), 32'd0);
    apb_rd(A_PEND, 32'h0);
    check("edge_no_regrant", 32'(valid), 32'd0);
    active = 16'h0010;
    tick();
    active = '0;
    tick();
    check("edge_grant2", {27'd0, valid, id}, {27'd0, 1'b1, 4'd4});
    serviced = 1'b1;
    active   = 16'h0010;
    tick();
    serviced = 1'b0;
    active   = '0;
    check("edge_set_ack_gap", 32'(valid), 32'd0);
    tick();
    check("edge_set_beats_ack", {27'd0, valid, id}, {27'd0, 1'b1, 4'd4});
    apb_rd(A_PEND, 32'h10);

    // W1C while in service, then no further grant
    apb_wr(A_PEND, 32'h10);
    apb_rd(A_PEND, 32'h0);
    check("w1c_hold", 32'(valid), 32'd1);
    ack();
    tick(); tick();
    check("w1c_no_grant", 32'(valid), 32'd0);

    // Config writes during service don't disturb the presented id
    apb_wr(A_MODE, 32'h0);
    active = 16'h0004;
    tick();
    check("svc_id2", {27'd0, valid, id}, {27'd0, 1'b1, 4'd2});
    apb_rd(A_STAT, 32'h12);
    apb_wr(2, 32'd0);
    apb_wr(A_EN, 32'd0);
    check("svc_hold", {27'd0, valid, id}, {27'd0, 1'b1, 4'd2});
    ack();
    tick(); tick();
    check("svc_after_ack", 32'(valid), 32'd0);

    // Reset in the middle of service
    apb_wr(A_EN, 32'hFFFF);
    apb_wr(2, 32'd5);
    tick();
    check("prerst_grant", {27'd0, valid, id}, {27'd0, 1'b1, 4'd2});
    prst = 1'b0;
    tick();
    check("midrst_out", {27'd0, valid, id}, 32'd0);
    prst = 1'b1;
    active = '0;
    apb_rd(A_EN, 32'd0);
    apb_rd(2, 32'd0);
    apb_rd(A_MODE, 32'd0);
    apb_rd(A_STAT, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
